// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the L1 data cache.
package dcache_pkg;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
   localparam int IDX_W  = 5;
   localparam int OFF_W  = 5;
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINES  = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILL} state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [2:0] addr_word(input logic [ADDR_W-1:0] a);
      return a[4:2];
   endfunction

   // Replace one 32-bit word of a line, leaving the other seven untouched.
   function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0] line,
                                                    input logic [2:0]        sel,
                                                    input logic [31:0]       data);
      logic [LINE_W-1:0] r;
      r = line;
      r[32*sel +: 32] = data;
      return r;
   endfunction
endpackage

// File: rtl/dcache_tag_store.sv
// Per-line valid/dirty/tag flops: one combinational read port, one write port.
module dcache_tag_store
   import dcache_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic             rd_dirty,
   output logic [TAG_W-1:0] rd_tag,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_dirty,
   input  logic [TAG_W-1:0] wr_tag
);
   logic [LINES-1:0]            valid_q;
   logic [LINES-1:0]            dirty_q;
   logic [LINES-1:0][TAG_W-1:0] tag_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
         tag_q   <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
         tag_q[wr_idx]   <= wr_tag;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit path, victim
// write-back, line refill, and replay of the stalled CPU access.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p1_req_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [31:0]       p1_data_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   output logic [IDX_W-1:0]  sram_addr_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [LINE_W-1:0] sram_data_i,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] miss_addr;
   logic [LINE_W-1:0] fill_line;
   logic [IDX_W-1:0]  cur_idx;
   logic              tag_valid, tag_dirty;
   logic [TAG_W-1:0]  tag_rd;
   logic              hit;
   logic              tw_en, tw_dirty;
   logic [TAG_W-1:0]  tw_tag;

   // Outside IDLE every lookup uses the latched miss address, never the live CPU port.
   assign cur_idx = (state == IDLE) ? addr_idx(p1_addr_i) : addr_idx(miss_addr);
   assign hit     = p1_req_i && (state == IDLE) && tag_valid && (tag_rd == addr_tag(p1_addr_i));

   dcache_tag_store u_tags (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (cur_idx),
      .rd_valid (tag_valid),
      .rd_dirty (tag_dirty),
      .rd_tag   (tag_rd),
      .wr_en    (tw_en),
      .wr_idx   (cur_idx),
      .wr_dirty (tw_dirty),
      .wr_tag   (tw_tag)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         miss_addr <= '0;
         fill_line <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt != IDLE) miss_addr <= p1_addr_i;
         if (state == REFILL && mem_ack_i)       fill_line <= mem_data_i;
      end
   end

   always_comb begin
      state_nxt     = state;
      p1_stall_o    = 1'b0;
      p1_data_o     = '0;
      sram_addr_o   = '0;
      sram_data_o   = '0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      tw_en         = 1'b0;
      tw_dirty      = 1'b0;
      tw_tag        = '0;
      case (state)
         IDLE: begin
            if (p1_req_i) begin
               sram_enable_o = 1'b1;
               sram_addr_o   = cur_idx;
               if (hit) begin
                  if (p1_write_i) begin
                     sram_write_o = 1'b1;
                     sram_data_o  = word_merge(sram_data_i, addr_word(p1_addr_i), p1_data_i);
                     tw_en        = 1'b1;
                     tw_dirty     = 1'b1;
                     tw_tag       = tag_rd;
                  end else begin
                     p1_data_o = sram_data_i[32*addr_word(p1_addr_i) +: 32];
                  end
               end else begin
                  p1_stall_o = 1'b1;
                  state_nxt  = (tag_valid && tag_dirty) ? WRITEBACK : REFILL;
               end
            end
         end
         WRITEBACK: begin
            p1_stall_o    = p1_req_i;
            sram_enable_o = 1'b1;
            sram_addr_o   = cur_idx;
            mem_enable_o  = 1'b1;
            mem_write_o   = 1'b1;
            mem_addr_o    = {tag_rd, cur_idx, 5'b0};
            mem_data_o    = sram_data_i;
            if (mem_ack_i) state_nxt = REFILL;
         end
         REFILL: begin
            p1_stall_o   = p1_req_i;
            mem_enable_o = 1'b1;
            mem_addr_o   = {addr_tag(miss_addr), cur_idx, 5'b0};
            if (mem_ack_i) state_nxt = FILL;
         end
         FILL: begin
            p1_stall_o    = p1_req_i;
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
            sram_addr_o   = cur_idx;
            sram_data_o   = fill_line;
            tw_en         = 1'b1;
            tw_dirty      = 1'b0;
            tw_tag        = addr_tag(miss_addr);
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench: SRAM and memory models plus a flat word-level view of what the CPU should read.
module tb_dcache_controller;
   logic         clk_i = 0;
   logic         rst_i;
   logic         p1_req_i, p1_write_i;
   logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
   logic         p1_stall_o;
   logic [4:0]   sram_addr_o;
   logic [255:0] sram_data_o, sram_data_i;
   logic         sram_enable_o, sram_write_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;

   int checks = 0, failures = 0;

   dcache_controller dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
      .sram_write_o(sram_write_o), .sram_data_i(sram_data_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   // Data SRAM: combinational read, write captured on rising edge.
   logic [255:0] sram [32];
   initial for (int i = 0; i < 32; i++) sram[i] = '0;
   always @(posedge clk_i) if (sram_enable_o && sram_write_o) sram[sram_addr_o] <= sram_data_o;
   assign sram_data_i = sram[sram_addr_o];

   // ref_w: what the CPU must observe; bmem_w: backing memory contents.
   logic [31:0] ref_w  [int unsigned];
   logic [31:0] bmem_w [int unsigned];
   bit          res_v [32];
   logic [21:0] res_t [32];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h400) return 32'hDEADBEEF;
      return a * 32'h9E3779B1 + 32'h1357;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_w.exists(a >> 2) ? ref_w[a >> 2] : init_word({a[31:2], 2'b0});
   endfunction

   function automatic logic [31:0] bm_rd(input logic [31:0] a);
      return bmem_w.exists(a >> 2) ? bmem_w[a >> 2] : init_word({a[31:2], 2'b0});
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = ref_rd(la + 32'(4*i));
      return l;
   endfunction

   function automatic logic [255:0] bm_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = bm_rd(la + 32'(4*i));
      return l;
   endfunction

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory responder: acks after fixed_delay cycles (random when negative).
   int          fixed_delay = 0;
   int          wb_cnt = 0, rf_cnt = 0;
   logic [31:0] last_rf_addr, last_wb_addr;
   logic [255:0] last_wb_data;

   initial begin
      bit          pend;
      logic [31:0] pend_addr;
      logic        pend_wr;
      int          wait_cnt;
      pend = 0; pend_addr = '0; pend_wr = 0; wait_cnt = 0;
      mem_ack_i = 0; mem_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         mem_ack_i = 0;
         if (!rst_i) pend = 0;
         else if (pend) begin
            chk("mem_en_hold", mem_enable_o, 1'b1);
            chk("mem_addr_hold", mem_addr_o, pend_addr);
            chk("mem_wr_hold", mem_write_o, pend_wr);
         end else if (mem_enable_o) begin
            pend = 1; pend_addr = mem_addr_o; pend_wr = mem_write_o;
            wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            chk("mem_addr_align", mem_addr_o[4:0], 5'd0);
            if (pend_wr) wb_cnt++;
            else begin rf_cnt++; last_rf_addr = mem_addr_o; end
         end
         if (pend && rst_i) begin
            if (wait_cnt == 0) begin
               if (pend_wr) begin
                  last_wb_addr = pend_addr;
                  last_wb_data = mem_data_o;
                  chk("wb_data", mem_data_o, ref_line(pend_addr));
                  for (int i = 0; i < 8; i++) bmem_w[(pend_addr >> 2) + i] = mem_data_o[32*i +: 32];
               end else begin
                  mem_data_i = bm_line(pend_addr);
               end
               mem_ack_i = 1;
               pend = 0;
            end else wait_cnt--;
         end
      end
   end

   task automatic cpu_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rdata, output int lat);
      bit exp_hit;
      exp_hit = res_v[a[9:5]] && (res_t[a[9:5]] == a[31:10]);
      p1_req_i = 1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
      @(negedge clk_i);
      chk(wr ? "st_first_stall" : "ld_first_stall", p1_stall_o, !exp_hit);
      lat = 0;
      while (p1_stall_o && lat < 300) begin @(negedge clk_i); lat++; end
      if (p1_stall_o) chk("stall_timeout", p1_stall_o, 1'b0);
      rdata = p1_data_o;
      if (!wr) chk("ld_data", p1_data_o, ref_rd(a));
      else ref_w[a >> 2] = d;
      @(posedge clk_i); #1;
      p1_req_i = 0; p1_write_i = 0;
      res_v[a[9:5]] = 1; res_t[a[9:5]] = a[31:10];
   endtask

   initial begin
      logic [31:0] rd;
      int          lat, w0, r0, n;
      rst_i = 0; p1_req_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
      for (int i = 0; i < 32; i++) begin res_v[i] = 0; res_t[i] = '0; end
      #12;
      chk("rst_stall", p1_stall_o, 1'b0);
      chk("rst_mem_en", mem_enable_o, 1'b0);
      chk("rst_sram_en", {sram_enable_o, sram_write_o, mem_write_o}, 3'b0);
      chk("rst_outs", {p1_data_o, mem_addr_o, sram_addr_o}, '0);
      chk("rst_mem_data", mem_data_o, '0);
      @(posedge clk_i); #1 rst_i = 1;

      // 1: cold load miss, refill, replay hit
      fixed_delay = 0;
      cpu_access(0, 32'h400, 0, rd, lat);
      chk("t1_rf_addr", last_rf_addr, 32'h400);
      chk("t1_data", rd, 32'hDEADBEEF);
      chk("t1_lat", lat, 3);

      // 2: neighbouring word hits with no memory traffic
      r0 = rf_cnt;
      cpu_access(0, 32'h404, 0, rd, lat);
      chk("t2_lat", lat, 0);
      chk("t2_no_mem", rf_cnt, r0);

      // 3: dirty conflict miss writes victim back
      cpu_access(1, 32'h408, 32'h55AA55AA, rd, lat);
      chk("t3_st_lat", lat, 0);
      w0 = wb_cnt;
      cpu_access(0, 32'h800, 0, rd, lat);
      chk("t3_wb_cnt", wb_cnt, w0 + 1);
      chk("t3_wb_addr", last_wb_addr, 32'h400);
      chk("t3_wb_word2", last_wb_data[95:64], 32'h55AA55AA);
      chk("t3_rf_addr", last_rf_addr, 32'h800);

      // 4: store miss to clean line allocates then merges
      w0 = wb_cnt;
      cpu_access(1, 32'h1000, 32'hCAFEF00D, rd, lat);
      chk("t4_no_wb", wb_cnt, w0);
      chk("t4_rf_addr", last_rf_addr, 32'h1000);
      cpu_access(0, 32'h1000, 0, rd, lat);
      chk("t4_reload", rd, 32'hCAFEF00D);
      chk("t4_hit", lat, 0);

      // 5: slow memory, request must stay stable
      fixed_delay = 10;
      w0 = wb_cnt; r0 = rf_cnt;
      cpu_access(1, 32'h1004, 32'h0BADF00D, rd, lat);
      cpu_access(0, 32'h400, 0, rd, lat);
      chk("t5_wb_addr", last_wb_addr, 32'h1000);
      chk("t5_counts", {wb_cnt, rf_cnt}, {w0 + 1, r0 + 1});
      chk("t5_data", rd, 32'hDEADBEEF);

      // 6: reset during refill drops the request; replay refetches
      @(posedge clk_i); #1;
      p1_req_i = 1; p1_write_i = 0; p1_addr_i = 32'h2000;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!(mem_enable_o && !mem_write_o) && n < 50);
      chk("t6_in_refill", {mem_enable_o, mem_write_o}, 2'b10);
      @(posedge clk_i); #1 rst_i = 0;
      #1 chk("t6_rst_mem_en", mem_enable_o, 1'b0);
      @(posedge clk_i); #1 p1_req_i = 0;
      @(posedge clk_i); #1 rst_i = 1;
      ref_w = bmem_w;
      for (int i = 0; i < 32; i++) res_v[i] = 0;
      r0 = rf_cnt;
      cpu_access(0, 32'h2000, 0, rd, lat);
      chk("t6_refetch", rf_cnt, r0 + 1);
      chk("t6_rf_addr", last_rf_addr, 32'h2000);

      // random traffic over a few conflicting tags and indices
      fixed_delay = -1;
      for (int k = 0; k < 300; k++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
         cpu_access(1'($urandom_range(0, 1)), a, $urandom, rd, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
